awg_wave_player: RTL
====================

Name: awg_wave_player

Overview:
- Per-channel playback engine sitting directly downstream of the trigger-delay stage.
- Consumes the `tx_id` / `tx_ena` pulse pair for one DAC channel and queues the requested waveform IDs.
- For each ID it reads a waveform descriptor (start address, length) from the descriptor RAM, then streams that many sample words from the sample RAM to the DAC data path.
- One instance per channel (four in the AWG top level).

Parameters:
- ID_WIDTH, 11, width of waveform ID (matches the trigger-delay stage output).
- ADDR_WIDTH, 16, sample RAM word address width.
- LEN_WIDTH, 16, waveform length field width, in sample words.
- DATA_WIDTH, 64, sample word width (4 x 16-bit DAC samples per 250 MHz clock).
- QDEPTH_LOG2, 2, log2 of the pending-ID queue depth (default 4 entries).

Ports:
- I_clk_250mhz  in  1  system clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_tx_id  in  ID_WIDTH  waveform ID from the trigger-delay stage.
- I_tx_ena  in  1  one-cycle request strobe; I_tx_id is valid while it is high.
- I_clr_ovf  in  1  synchronous clear of O_overflow.
- O_desc_rd_addr  out  ID_WIDTH  descriptor RAM read address.
- I_desc_rd_data  in  ADDR_WIDTH+LEN_WIDTH  {start[ADDR_WIDTH-1:0] in upper bits, len in lower bits}; 1-cycle read latency.
- O_smp_rd_en  out  1  sample RAM read enable.
- O_smp_rd_addr  out  ADDR_WIDTH  sample RAM read address.
- I_smp_rd_data  in  DATA_WIDTH  sample RAM data; valid 2 cycles after O_smp_rd_en.
- O_dac_data  out  DATA_WIDTH  sample word to the DAC interface.
- O_dac_valid  out  1  O_dac_data is valid.
- O_busy  out  1  high when the state machine is not IDLE, or the queue is non-empty, or the output pipeline holds valid data.
- O_overflow  out  1  sticky; set when a request is dropped.
- O_state  out  3  current state encoding, for debug.

Behaviour:
Reset:
- All outputs 0, queue empty, state IDLE.
- Reset is asynchronous: an assertion mid-playback aborts at once, with no completion of the current waveform.

Queue:
- Synchronous FIFO, 2^QDEPTH_LOG2 entries.
- I_tx_ena high and queue not full: I_tx_id is pushed.
- I_tx_ena high and queue full, with no pop in the same cycle: the request is dropped and O_overflow is set.
- Push and pop in the same cycle while full: the push is accepted and no overflow occurs.
- O_overflow is cleared by I_clr_ovf. If I_clr_ovf coincides with a new drop, the set wins.

State machine (registered outputs):
- IDLE (0): if the queue is non-empty, pop, O_desc_rd_addr <= head ID, go to DESC_RD.
- DESC_RD (1): wait one cycle for RAM latency; go to DESC_LAT.
- DESC_LAT (2): capture start/len from I_desc_rd_data into internal registers.
  - len == 0: go to IDLE; nothing is played and this is not an error.
  - otherwise: go to PLAY.
- PLAY (3):
  - O_smp_rd_en = 1; O_smp_rd_addr = start + k for k = 0..len-1 on consecutive cycles.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - On the cycle issuing k = len-1: if the queue is non-empty, pop, load O_desc_rd_addr, go to DESC_RD; else go to IDLE.
- Codes 4-7 are unused and must return to IDLE.

Output path:
- Two-stage valid shift register tracks O_smp_rd_en.
- O_dac_valid is high exactly 2 cycles after each O_smp_rd_en cycle, with O_dac_data = I_smp_rd_data registered in that cycle.
- O_dac_data = 0 whenever O_dac_valid = 0.

Latency and throughput:
- I_tx_ena at cycle T, queue empty, state IDLE: first O_smp_rd_en at T+4; first O_dac_valid at T+6.
- Back-to-back waveforms: exactly 2 idle read cycles (DESC_RD, DESC_LAT) between the last read of one waveform and the first read of the next.
- Steady state: one sample word per clock.

Other rules:
- Descriptor contents are sampled only in DESC_LAT; RAM changes during PLAY do not affect the current waveform.
- ID 0 is a legal ID; no special meaning.

Test Plan:
1. Desc[5] = {start 0x0100, len 4}; single I_tx_ena with id 5 at T -> O_smp_rd_addr 0x0100..0x0103 at T+4..T+7; O_dac_valid high T+6..T+9 with the RAM words in order; O_busy low by T+10.
2. Desc[1] = {0x0010, 2}, Desc[2] = {0x0020, 3}; ena id 1 then id 2 on the next cycle -> reads 0x10, 0x11, two gap cycles, then 0x20..0x22; no overflow.
3. Desc[7] = {0xFFFE, 4} -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
4. Desc[3] len 0; ena id 3 -> no O_smp_rd_en and no O_dac_valid; FSM returns to IDLE 3 cycles after the pop.
5. Desc[9] len 100; 6 enas for id 9 during playback -> first 4 beyond the in-flight waveform are queued; the later drops set O_overflow; O_overflow is held until an I_clr_ovf pulse clears it; the queued waveforms still play completely.
6. Assert I_rst_n low during PLAY of a len-50 waveform at k = 20 -> outputs 0 immediately (asynchronous); after release: IDLE, queue empty, no residual O_dac_valid.

Source files
------------

// File: rtl/awg_wave_player_if.sv
// Bus bundle for one AWG playback channel: trigger requests, descriptor RAM,
// sample RAM and the DAC-facing stream. The player uses the slave modport;
// whatever drives requests and hosts the RAMs uses the master modport.
interface awg_wave_player_if #(
  parameter int ID_WIDTH   = 11,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]             I_tx_id;
  logic                            I_tx_ena;
  logic                            I_clr_ovf;
  logic [ID_WIDTH-1:0]             O_desc_rd_addr;
  logic [ADDR_WIDTH+LEN_WIDTH-1:0] I_desc_rd_data;
  logic                            O_smp_rd_en;
  logic [ADDR_WIDTH-1:0]           O_smp_rd_addr;
  logic [DATA_WIDTH-1:0]           I_smp_rd_data;
  logic [DATA_WIDTH-1:0]           O_dac_data;
  logic                            O_dac_valid;
  logic                            O_busy;
  logic                            O_overflow;
  logic [2:0]                      O_state;

  modport slave (
    input  I_tx_id, I_tx_ena, I_clr_ovf, I_desc_rd_data, I_smp_rd_data,
    output O_desc_rd_addr, O_smp_rd_en, O_smp_rd_addr, O_dac_data,
           O_dac_valid, O_busy, O_overflow, O_state
  );

  modport master (
    output I_tx_id, I_tx_ena, I_clr_ovf, I_desc_rd_data, I_smp_rd_data,
    input  O_desc_rd_addr, O_smp_rd_en, O_smp_rd_addr, O_dac_data,
           O_dac_valid, O_busy, O_overflow, O_state
  );
endinterface

// File: rtl/awg_wave_player.sv
// Per-channel waveform playback engine. Queues waveform IDs from the
// trigger-delay stage, fetches each descriptor {start, len}, then streams
// len sample words from the sample RAM to the DAC path at one word per clock.
module awg_wave_player #(
  parameter int ID_WIDTH    = 11,
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic              I_clk_250mhz,
  input  logic              I_rst_n,
  awg_wave_player_if.slave  bus
);

  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] QCNT_FULL = (QDEPTH_LOG2+1)'(QDEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DESC_RD  = 3'd1,
    DESC_LAT = 3'd2,
    PLAY     = 3'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     q_mem [QDEPTH];
  logic [QDEPTH_LOG2-1:0]  q_wr, q_rd;
  logic [QDEPTH_LOG2:0]    q_cnt;
  logic                    q_empty, q_full, q_push, q_pop, q_drop;
  logic [ID_WIDTH-1:0]     q_head;

  logic [ID_WIDTH-1:0]     desc_addr, desc_addr_nxt;
  logic [ADDR_WIDTH-1:0]   rd_addr, rd_addr_nxt;
  logic                    rd_en, rd_en_nxt;
  logic [LEN_WIDTH-1:0]    remain, remain_nxt;
  logic [ADDR_WIDTH-1:0]   desc_start;
  logic [LEN_WIDTH-1:0]    desc_len;
  logic                    vld_p0, vld_p1;
  logic                    overflow;

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == QCNT_FULL);
  assign q_head  = q_mem[q_rd];
  // A full queue still accepts a request when the engine pops in the same cycle.
  assign q_push  = bus.I_tx_ena && (!q_full || q_pop);
  assign q_drop  = bus.I_tx_ena && q_full && !q_pop;

  assign desc_start = bus.I_desc_rd_data[ADDR_WIDTH+LEN_WIDTH-1 -: ADDR_WIDTH];
  assign desc_len   = bus.I_desc_rd_data[LEN_WIDTH-1:0];

  // Pending-ID storage; contents need no reset, validity is tracked by q_cnt.
  always_ff @(posedge I_clk_250mhz) begin
    if (q_push) q_mem[q_wr] <= bus.I_tx_id;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wr <= q_wr + QDEPTH_LOG2'(1);
      if (q_pop)  q_rd <= q_rd + QDEPTH_LOG2'(1);
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + (QDEPTH_LOG2+1)'(1);
        2'b01:   q_cnt <= q_cnt - (QDEPTH_LOG2+1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
    if (!I_rst_n)           overflow <= 1'b0;
    else if (q_drop)        overflow <= 1'b1;
    else if (bus.I_clr_ovf) overflow <= 1'b0;
  end

  // State register and registered RAM-facing outputs.
  always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= IDLE;
      desc_addr <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      remain    <= '0;
    end else begin
      state     <= state_nxt;
      desc_addr <= desc_addr_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_en     <= rd_en_nxt;
      remain    <= remain_nxt;
    end
  end

  // Next-state logic: remain counts the reads still to issue after the current one.
  always_comb begin
    state_nxt     = state;
    q_pop         = 1'b0;
    desc_addr_nxt = desc_addr;
    rd_addr_nxt   = rd_addr;
    rd_en_nxt     = 1'b0;
    remain_nxt    = remain;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop         = 1'b1;
          desc_addr_nxt = q_head;
          state_nxt     = DESC_RD;
        end
      end
      DESC_RD: state_nxt = DESC_LAT;
      DESC_LAT: begin
        if (desc_len != '0) begin
          state_nxt   = PLAY;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = desc_start;
          remain_nxt  = desc_len - LEN_WIDTH'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      PLAY: begin
        if (remain == '0) begin
          if (!q_empty) begin
            q_pop         = 1'b1;
            desc_addr_nxt = q_head;
            state_nxt     = DESC_RD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);
          remain_nxt  = remain - LEN_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid tracks the sample RAM's two-cycle read latency.
  always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      // stage p0: read issued last cycle
      vld_p0 <= rd_en;
      // stage p1: RAM word present on I_smp_rd_data
      vld_p1 <= vld_p0;
    end
  end

  // The sample RAM output is already registered; gate it so idle cycles read as zero.
  assign bus.O_dac_data     = vld_p1 ? bus.I_smp_rd_data : '0;
  assign bus.O_dac_valid    = vld_p1;
  assign bus.O_desc_rd_addr = desc_addr;
  assign bus.O_smp_rd_en    = rd_en;
  assign bus.O_smp_rd_addr  = rd_addr;
  assign bus.O_overflow     = overflow;
  assign bus.O_state        = state;
  assign bus.O_busy         = (state != IDLE) || !q_empty || vld_p0 || vld_p1;

endmodule
